// File: rtl/rgb_channel_scheduler.sv
// rgb_channel_scheduler: three BCD intensity channels sharing one saturating
// inc/dec unit under round-robin arbitration, with direct preset loads.
module rgb_channel_scheduler #(
  parameter logic [7:0] MAX_CNT   = 8'h99,
  parameter logic [7:0] RESET_VAL = 8'h00
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [2:0] inc_in,
  input  logic [2:0] dec_in,
  input  logic       load_en,
  input  logic [1:0] load_ch,
  input  logic [7:0] load_value,
  output logic [7:0] value_r,
  output logic [7:0] value_g,
  output logic [7:0] value_b,
  output logic       upd_valid,
  output logic [1:0] upd_ch,
  output logic       upd_sat,
  output logic       overrun,
  output logic       load_err
);
  typedef enum logic [1:0] {NONE, INC, DEC} slot_t;
  slot_t      slot_q [3];
  slot_t      slot_d [3];
  logic [7:0] val_q [3];
  logic [7:0] val_d [3];
  logic [1:0] rr_q, rr_d, gnt_c;
  logic       gnt_v, grant, load_ok, ovr_d, sat, up;
  logic [7:0] cur, res;
  always_comb begin
    gnt_v = 1'b0;
    gnt_c = 2'd0;
    // walk offsets from farthest to nearest so the nearest pending channel wins
    for (int i = 2; i >= 0; i--) begin
      if (slot_q[(int'(rr_q) + i) % 3] != NONE) begin
        gnt_v = 1'b1;
        gnt_c = 2'((int'(rr_q) + i) % 3);
      end
    end
  end
  assign load_ok = load_en && load_ch != 2'd3 && load_value[7:4] <= 4'd9 &&
                   load_value[3:0] <= 4'd9 && load_value <= MAX_CNT;
  assign grant = gnt_v && !(load_ok && load_ch == gnt_c);
  assign cur   = val_q[gnt_c];
  assign up    = slot_q[gnt_c] == INC;
  assign sat   = up ? cur == MAX_CNT : cur == 8'h00;
  assign res   = sat ? cur :
                 up  ? (cur[3:0] == 4'd9 ? {cur[7:4] + 4'd1, 4'd0} : {cur[7:4], cur[3:0] + 4'd1}) :
                       (cur[3:0] == 4'd0 ? {cur[7:4] - 4'd1, 4'd9} : {cur[7:4], cur[3:0] - 4'd1});
  assign rr_d  = grant ? (gnt_c == 2'd2 ? 2'd0 : gnt_c + 2'd1) : rr_q;
  always_comb begin
    ovr_d = 1'b0;
    for (int c = 0; c < 3; c++) begin
      slot_t base, pd;
      base      = (grant && gnt_c == 2'(c)) ? NONE : slot_q[c];
      pd        = inc_in[c] ? INC : DEC;
      val_d[c]  = (grant && gnt_c == 2'(c)) ? res : val_q[c];
      slot_d[c] = base;
      if (load_ok && load_ch == 2'(c)) begin
        slot_d[c] = NONE;
        val_d[c]  = load_value;
      end else if (inc_in[c] ^ dec_in[c]) begin
        slot_d[c] = base == NONE ? pd : base == pd ? base : NONE;
        ovr_d     = ovr_d | (base == pd);
      end
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int c = 0; c < 3; c++) begin
        slot_q[c] <= NONE;
        val_q[c]  <= RESET_VAL;
      end
      rr_q      <= 2'd0;
      upd_valid <= 1'b0;
      upd_ch    <= 2'd0;
      upd_sat   <= 1'b0;
      overrun   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      for (int c = 0; c < 3; c++) begin
        slot_q[c] <= slot_d[c];
        val_q[c]  <= val_d[c];
      end
      rr_q      <= rr_d;
      upd_valid <= grant;
      upd_ch    <= grant ? gnt_c : upd_ch;
      upd_sat   <= grant & sat;
      overrun   <= ovr_d;
      load_err  <= load_en & ~load_ok;
    end
  end
  assign value_r = val_q[0];
  assign value_g = val_q[1];
  assign value_b = val_q[2];
endmodule

// File: tb/tb_rgb_channel_scheduler.sv
// tb_rgb_channel_scheduler: scoreboard bench; expected updates are queued as
// stimulus is applied and retired by a monitor watching upd_valid.
module tb_rgb_channel_scheduler;
  typedef struct packed {logic [1:0] ch; logic [7:0] val; logic sat;} upd_t;
  logic       CLK = 1'b0, RST = 1'b0;
  logic [2:0] inc_in = 3'd0, dec_in = 3'd0;
  logic       load_en = 1'b0;
  logic [1:0] load_ch = 2'd0;
  logic [7:0] load_value = 8'h00;
  logic [7:0] value_r, value_g, value_b;
  logic       upd_valid, upd_sat, overrun, load_err;
  logic [1:0] upd_ch;
  logic [2:0] inc2 = 3'd0;
  logic       load_en2 = 1'b0;
  logic [1:0] load_ch2 = 2'd0;
  logic [7:0] load_value2 = 8'h00;
  logic [7:0] r2, g2, b2;
  logic       uv2, us2, ov2, le2;
  logic [1:0] uc2;
  int         total = 0, bad = 0;
  upd_t       exp_q[$];

  rgb_channel_scheduler u_dut (
    .CLK(CLK), .RST(RST), .inc_in(inc_in), .dec_in(dec_in), .load_en(load_en),
    .load_ch(load_ch), .load_value(load_value), .value_r(value_r), .value_g(value_g),
    .value_b(value_b), .upd_valid(upd_valid), .upd_ch(upd_ch), .upd_sat(upd_sat),
    .overrun(overrun), .load_err(load_err));

  rgb_channel_scheduler #(.MAX_CNT(8'h50)) u_lim (
    .CLK(CLK), .RST(RST), .inc_in(inc2), .dec_in(3'd0), .load_en(load_en2),
    .load_ch(load_ch2), .load_value(load_value2), .value_r(r2), .value_g(g2),
    .value_b(b2), .upd_valid(uv2), .upd_ch(uc2), .upd_sat(us2),
    .overrun(ov2), .load_err(le2));

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    upd_t a, e;
    if (upd_valid === 1'b1) begin
      a.ch  = upd_ch;
      a.sat = upd_sat;
      a.val = upd_ch == 2'd0 ? value_r : upd_ch == 2'd1 ? value_g : value_b;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_update got=%h exp=none", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          bad++;
          $display("FAIL update got=%h exp=%h", a, e);
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic [2:0] i, input logic [2:0] d);
    inc_in = i;
    dec_in = d;
    tick();
    inc_in = 3'd0;
    dec_in = 3'd0;
  endtask

  task automatic load(input logic [1:0] ch, input logic [7:0] v);
    load_en = 1'b1;
    load_ch = ch;
    load_value = v;
    tick();
    load_en = 1'b0;
  endtask

  task automatic push(input logic [1:0] ch, input logic [7:0] v, input logic s);
    exp_q.push_back('{ch: ch, val: v, sat: s});
  endtask

  task automatic drain;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain pending=%0d exp=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset;
    RST = 1'b1;
    tick(2);
    RST = 1'b0;
  endtask

  task automatic test_reset;
    RST = 1'b1;
    inc_in = 3'b111;
    tick(2);
    RST = 1'b0;
    inc_in = 3'd0;
    total++;
    if ({value_r, value_g, value_b} !== 24'h0 || {r2, g2, b2} !== 24'h0) begin
      bad++;
      $display("FAIL reset_values got=%h_%h_%h exp=000000", value_r, value_g, value_b);
    end
    total++;
    if ({upd_valid, upd_ch, upd_sat, overrun, load_err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b exp=000000", {upd_valid, upd_ch, upd_sat, overrun, load_err});
    end
    tick(4);
    total++;
    if ({value_r, value_g, value_b} !== 24'h0) begin
      bad++;
      $display("FAIL reset_discard got=%h_%h_%h exp=000000", value_r, value_g, value_b);
    end
  endtask

  task automatic test_single_inc;
    push(2'd0, 8'h01, 1'b0);
    pulse(3'b001, 3'b000);
    total++;
    if (value_r !== 8'h00) begin
      bad++;
      $display("FAIL single_early got=%h exp=00", value_r);
    end
    tick();
    total++;
    if (value_r !== 8'h01 || value_g !== 8'h00 || value_b !== 8'h00) begin
      bad++;
      $display("FAIL single_value got=%h_%h_%h exp=010000", value_r, value_g, value_b);
    end
    drain();
  endtask

  task automatic test_round_robin;
    do_reset();
    for (int n = 1; n <= 2; n++) begin
      for (int c = 0; c < 3; c++) push(2'(c), 8'(n), 1'b0);
      pulse(3'b111, 3'b000);
      drain();
    end
  endtask

  task automatic test_overrun;
    do_reset();
    push(2'd0, 8'h01, 1'b0);
    push(2'd1, 8'h01, 1'b0);
    push(2'd0, 8'h02, 1'b0);
    inc_in = 3'b011;
    tick();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_first got=%b exp=0", overrun);
    end
    tick();
    inc_in = 3'd0;
    total++;
    if (overrun !== 1'b1) begin
      bad++;
      $display("FAIL overrun_set got=%b exp=1", overrun);
    end
    tick();
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL overrun_clear got=%b exp=0", overrun);
    end
    drain();
  endtask

  task automatic test_cancel;
    do_reset();
    push(2'd0, 8'h01, 1'b0);
    push(2'd1, 8'h01, 1'b0);
    pulse(3'b111, 3'b000);
    pulse(3'b000, 3'b100);
    drain();
    total++;
    if (value_b !== 8'h00 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL cancel got=%h/%b exp=00/0", value_b, overrun);
    end
  endtask

  task automatic test_load_sat;
    load(2'd0, 8'h09);
    total++;
    if (value_r !== 8'h09 || load_err !== 1'b0) begin
      bad++;
      $display("FAIL load_value got=%h/%b exp=09/0", value_r, load_err);
    end
    push(2'd0, 8'h10, 1'b0);
    pulse(3'b001, 3'b000);
    drain();
    load(2'd0, 8'h99);
    push(2'd0, 8'h99, 1'b1);
    pulse(3'b001, 3'b000);
    drain();
    load(2'd1, 8'h00);
    push(2'd1, 8'h00, 1'b1);
    pulse(3'b000, 3'b010);
    drain();
    load(2'd2, 8'h40);
    push(2'd2, 8'h39, 1'b0);
    pulse(3'b000, 3'b100);
    drain();
  endtask

  task automatic test_load_priority;
    pulse(3'b001, 3'b000);
    load(2'd0, 8'h42);
    total++;
    if (value_r !== 8'h42 || upd_valid !== 1'b0) begin
      bad++;
      $display("FAIL load_priority got=%h/%b exp=42/0", value_r, upd_valid);
    end
    tick(3);
    total++;
    if (value_r !== 8'h42) begin
      bad++;
      $display("FAIL load_clears_slot got=%h exp=42", value_r);
    end
  endtask

  task automatic test_reject;
    load(2'd0, 8'h1A);
    total++;
    if (load_err !== 1'b1 || value_r !== 8'h42) begin
      bad++;
      $display("FAIL reject_nibble got=%b/%h exp=1/42", load_err, value_r);
    end
    tick();
    total++;
    if (load_err !== 1'b0) begin
      bad++;
      $display("FAIL reject_pulse got=%b exp=0", load_err);
    end
    load(2'd3, 8'h05);
    total++;
    if (load_err !== 1'b1 || {value_r, value_g, value_b} !== 24'h420039) begin
      bad++;
      $display("FAIL reject_ch got=%b/%h%h%h exp=1/420039", load_err, value_r, value_g, value_b);
    end
    load_en2 = 1'b1;
    load_ch2 = 2'd0;
    load_value2 = 8'h51;
    tick();
    total++;
    if (le2 !== 1'b1 || r2 !== 8'h00) begin
      bad++;
      $display("FAIL reject_max got=%b/%h exp=1/00", le2, r2);
    end
    load_value2 = 8'h50;
    tick();
    load_en2 = 1'b0;
    total++;
    if (le2 !== 1'b0 || r2 !== 8'h50) begin
      bad++;
      $display("FAIL accept_max got=%b/%h exp=0/50", le2, r2);
    end
    inc2 = 3'b001;
    tick();
    inc2 = 3'd0;
    tick();
    total++;
    if ({uv2, uc2, us2} !== 4'b1001 || r2 !== 8'h50) begin
      bad++;
      $display("FAIL sat_max got=%b/%h exp=1001/50", {uv2, uc2, us2}, r2);
    end
  endtask

  task automatic test_reset_pending;
    inc_in = 3'b111;
    tick();
    inc_in = 3'd0;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    total++;
    if ({value_r, value_g, value_b} !== 24'h0 || upd_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_pending got=%h%h%h/%b exp=000000/0", value_r, value_g, value_b, upd_valid);
    end
    tick(4);
    total++;
    if ({value_r, value_g, value_b} !== 24'h0) begin
      bad++;
      $display("FAIL reset_flush got=%h%h%h exp=000000", value_r, value_g, value_b);
    end
    for (int c = 0; c < 3; c++) push(2'(c), 8'h01, 1'b0);
    pulse(3'b111, 3'b000);
    drain();
  endtask

  initial begin
    test_reset();
    test_single_inc();
    test_round_robin();
    test_overrun();
    test_cancel();
    test_load_sat();
    test_load_priority();
    test_reject();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
